// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: debounces the three operation keys, queues presses,
// grants them one at a time by fixed priority, drives the board ALU with
// latched switch operands and captures its result and flags for display.
module alu_op_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int ALU_LAT         = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] sw,
    input  logic [3:1]  key_n,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_unsig,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow,
    input  logic        alu_compout,
    output logic [31:0] result,
    output logic        overflow_led,
    output logic        comp_flag,
    output logic        result_valid,
    output logic        busy,
    output logic [7:0]  op_count
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int WW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(ALU_LAT - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE   = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_CAPTURE = 2'd3;

    logic [2:0]    sync_meta;
    logic [2:0]    raw;
    logic [2:0]    raw_prev;
    logic [CW-1:0] deb_cnt;
    logic [2:0]    deb;
    logic [2:0]    deb_prev;
    logic [2:0]    press;
    logic [2:0]    pending;
    logic [2:0]    grant;
    logic [1:0]    state;
    logic [WW-1:0] wait_cnt;
    logic [7:0]    a_q;
    logic [7:0]    b_q;

    // Two-flop synchronizer; keys are inverted on entry so raw is active-high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= 3'b000;
            raw       <= 3'b000;
        end else begin
            sync_meta <= ~key_n;
            raw       <= sync_meta;
        end
    end

    // Shared debounce counter: any change restarts it, deb follows raw once stable long enough
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            raw_prev <= 3'b000;
            deb_cnt  <= '0;
            deb      <= 3'b000;
            deb_prev <= 3'b000;
        end else begin
            raw_prev <= raw;
            deb_prev <= deb;
            if (raw != raw_prev) begin
                deb_cnt <= '0;
            end else if (deb_cnt != CNT_MAX) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
            if ((raw == raw_prev) && (deb_cnt == CNT_MAX)) begin
                deb <= raw;
            end
        end
    end

    assign press = deb & ~deb_prev;

    // Fixed-priority grant, KEY[1] first; only offered while idle
    always_comb begin
        grant = 3'b000;
        if (state == S_IDLE) begin
            if (pending[0]) begin
                grant = 3'b001;
            end else if (pending[1]) begin
                grant = 3'b010;
            end else if (pending[2]) begin
                grant = 3'b100;
            end
        end
    end

    // Sticky request flags; a new press wins over a same-cycle grant clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= 3'b000;
        end else begin
            pending <= (pending & ~grant) | press;
        end
    end

    // Operation sequencer: latch operands, wait out the ALU, capture its outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            a_q          <= 8'h00;
            b_q          <= 8'h00;
            alu_unsig    <= 1'b0;
            alu_op       <= 3'b000;
            result       <= 32'h0;
            overflow_led <= 1'b0;
            comp_flag    <= 1'b0;
            result_valid <= 1'b0;
            op_count     <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant != 3'b000) begin
                        a_q       <= sw[7:0];
                        b_q       <= sw[15:8];
                        alu_unsig <= sw[16];
                        alu_op    <= grant;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    result_valid <= 1'b0;
                    wait_cnt     <= '0;
                    state        <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    result       <= alu_result;
                    overflow_led <= alu_overflow;
                    comp_flag    <= alu_compout;
                    result_valid <= 1'b1;
                    op_count     <= op_count + 8'd1;
                    alu_op       <= 3'b000;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign alu_a = {a_q, 24'h000000};
    assign alu_b = {b_q, 24'h000000};
    assign busy  = (state != S_IDLE);

endmodule
